// File: rtl/slv_guard_rst_ctrl.sv
// rtl/slv_guard_rst_ctrl.sv - subordinate guard recovery sequencer (isolate, reset pulse, ack wait, retry, clear)
module slv_guard_rst_ctrl #(
    parameter int IsoCycles   = 2,
    parameter int HoldCycles  = 16,
    parameter int AckTimeout  = 256,
    parameter int MaxRetries  = 3,
    parameter int EvtCntWidth = 8,
    localparam int RetryW     = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   guard_ena_i,
    input  logic                   rst_req_i,
    input  logic                   rst_stat_i,
    input  logic                   clr_fault_i,
    output logic                   isolate_o,
    output logic                   sub_rst_no,
    output logic                   reset_clear_o,
    output logic                   irq_o,
    output logic                   busy_o,
    output logic                   fault_o,
    output logic [RetryW-1:0]      retry_cnt_o,
    output logic [EvtCntWidth-1:0] evt_cnt_o
);

    localparam int MaxAB = (IsoCycles > HoldCycles) ? IsoCycles : HoldCycles;
    localparam int MaxLd = (MaxAB > AckTimeout) ? MaxAB : AckTimeout;
    localparam int CntW  = $clog2(MaxLd + 1);

    // ISOLATE and ASSERT last exactly N cycles, so they load N-1; WAIT_ACK spans AckTimeout+1 cycles.
    localparam logic [CntW-1:0]   ISO_LD    = CntW'(IsoCycles - 1);
    localparam logic [CntW-1:0]   HOLD_LD   = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0]   ACK_LD    = CntW'(AckTimeout);
    localparam logic [RetryW-1:0] MAX_RETRY = RetryW'(MaxRetries);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISOLATE,
        S_ASSERT,
        S_WAIT_ACK,
        S_CLEAR,
        S_FAULT
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [CntW-1:0]        r_cnt;
    logic [CntW-1:0]        w_cnt_ld;
    logic                   w_start;
    logic                   w_fault_entry;
    logic                   w_retry_inc;
    logic                   r_isolate;
    logic                   r_sub_rst_n;
    logic                   r_reset_clear;
    logic                   r_irq;
    logic                   r_busy;
    logic                   r_fault;
    logic [RetryW-1:0]      r_retry;
    logic [EvtCntWidth-1:0] r_evt;

    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_fault_entry = 1'b0;
        w_retry_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (guard_ena_i && rst_req_i) begin
                    w_state_nxt = S_ISOLATE;
                    w_start     = 1'b1;
                end
            end
            S_ISOLATE: begin
                if (r_cnt == '0) w_state_nxt = S_ASSERT;
            end
            S_ASSERT: begin
                if (r_cnt == '0) w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // An ack in the timeout cycle still counts as success.
                if (rst_stat_i) begin
                    w_state_nxt = S_CLEAR;
                end else if (r_cnt == '0) begin
                    if (r_retry < MAX_RETRY) begin
                        w_state_nxt = S_ASSERT;
                        w_retry_inc = 1'b1;
                    end else begin
                        w_state_nxt   = S_FAULT;
                        w_fault_entry = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (!rst_req_i) w_state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (clr_fault_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_ld = '0;
        case (w_state_nxt)
            S_ISOLATE:  w_cnt_ld = ISO_LD;
            S_ASSERT:   w_cnt_ld = HOLD_LD;
            S_WAIT_ACK: w_cnt_ld = ACK_LD;
            default:    w_cnt_ld = '0;
        endcase
    end

    // Output flops are loaded from the next-state decode so they track r_state exactly.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_isolate     <= 1'b0;
            r_sub_rst_n   <= 1'b1;
            r_reset_clear <= 1'b0;
            r_irq         <= 1'b0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_retry       <= '0;
            r_evt         <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= w_cnt_ld;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CntW'(1);
            end
            r_isolate     <= (w_state_nxt != S_IDLE);
            r_sub_rst_n   <= (w_state_nxt != S_ASSERT);
            r_reset_clear <= (w_state_nxt == S_CLEAR);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_fault       <= (w_state_nxt == S_FAULT);
            r_irq         <= w_start | w_fault_entry;
            if (w_start) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + RetryW'(1);
            end
            if (w_start && (r_evt != '1)) begin
                r_evt <= r_evt + EvtCntWidth'(1);
            end
        end
    end

    assign isolate_o     = r_isolate;
    assign sub_rst_no    = r_sub_rst_n;
    assign reset_clear_o = r_reset_clear;
    assign irq_o         = r_irq;
    assign busy_o        = r_busy;
    assign fault_o       = r_fault;
    assign retry_cnt_o   = r_retry;
    assign evt_cnt_o     = r_evt;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// tb/tb_slv_guard_rst_ctrl.sv - scoreboard bench for slv_guard_rst_ctrl
module tb_slv_guard_rst_ctrl;

    localparam int EvtMax = 3;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       guard_ena;
    logic       rst_req;
    logic       rst_stat;
    logic       clr_fault;
    logic       isolate;
    logic       sub_rst_n;
    logic       reset_clear;
    logic       irq;
    logic       busy;
    logic       fault;
    logic [0:0] retry_cnt;
    logic [1:0] evt_cnt;

    slv_guard_rst_ctrl #(
        .IsoCycles  (2),
        .HoldCycles (4),
        .AckTimeout (8),
        .MaxRetries (1),
        .EvtCntWidth(2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .guard_ena_i  (guard_ena),
        .rst_req_i    (rst_req),
        .rst_stat_i   (rst_stat),
        .clr_fault_i  (clr_fault),
        .isolate_o    (isolate),
        .sub_rst_no   (sub_rst_n),
        .reset_clear_o(reset_clear),
        .irq_o        (irq),
        .busy_o       (busy),
        .fault_o      (fault),
        .retry_cnt_o  (retry_cnt),
        .evt_cnt_o    (evt_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int F_ISO = 0, F_SRN = 1, F_RC = 2, F_BUSY = 3, F_FAULT = 4, F_RETRY = 5, F_EVT = 6;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    int   irq_q[$];
    int   tests = 0;
    int   fails = 0;
    int   e_evt = 0;

    function automatic int obs(input int sel);
        case (sel)
            F_ISO:   return int'(isolate);
            F_SRN:   return int'(sub_rst_n);
            F_RC:    return int'(reset_clear);
            F_BUSY:  return int'(busy);
            F_FAULT: return int'(fault);
            F_RETRY: return int'(retry_cnt);
            default: return int'(evt_cnt);
        endcase
    endfunction

    function automatic void push_exp(input int c, input int sel, input int val, input string name);
        exp_t e;
        int   i = 0;
        e.cyc  = c;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        while (i < q.size() && q[i].cyc <= c) i++;
        q.insert(i, e);
    endfunction

    always @(negedge clk) begin
        if (irq === 1'b1) begin
            tests++;
            if (irq_q.size() == 0) begin
                fails++;
                $display("FAIL irq_unexpected: pulse at cycle %0d, none required", cyc);
            end else begin
                int c;
                c = irq_q.pop_front();
                if (c != cyc) begin
                    fails++;
                    $display("FAIL irq_time: pulse at cycle %0d, required at %0d", cyc, c);
                end
            end
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            int   v;
            e = q.pop_front();
            v = obs(e.sel);
            tests++;
            if (e.cyc != cyc || v != e.val) begin
                fails++;
                $display("FAIL %s: cycle %0d got %0d, required %0d at cycle %0d", e.name, cyc, v, e.val, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_start(input int t);
        e_evt = (e_evt < EvtMax) ? e_evt + 1 : EvtMax;
        irq_q.push_back(t + 1);
        push_exp(t + 1, F_ISO, 1, "start_isolate");
        push_exp(t + 1, F_BUSY, 1, "start_busy");
        push_exp(t + 1, F_RETRY, 0, "start_retry");
        push_exp(t + 1, F_EVT, e_evt, "start_evt");
    endtask

    initial begin
        int t;
        int t2;
        rst_ni    = 1'b0;
        guard_ena = 1'b1;
        rst_req   = 1'b0;
        rst_stat  = 1'b0;
        clr_fault = 1'b0;
        run_to(2);
        push_exp(2, F_ISO, 0, "rst_isolate");
        push_exp(2, F_SRN, 1, "rst_sub_rst_n");
        push_exp(2, F_RC, 0, "rst_reset_clear");
        push_exp(2, F_BUSY, 0, "rst_busy");
        push_exp(2, F_FAULT, 0, "rst_fault");
        push_exp(2, F_RETRY, 0, "rst_retry");
        push_exp(2, F_EVT, 0, "rst_evt");
        run_to(3);
        rst_ni = 1'b1;

        // nominal sequence, ack 3 cycles after release
        run_to(10);
        t = cyc;
        rst_req = 1'b1;
        expect_start(t);
        push_exp(t + 2, F_SRN, 1, "nom_srn_iso");
        push_exp(t + 3, F_SRN, 0, "nom_srn_fall");
        push_exp(t + 6, F_SRN, 0, "nom_srn_last");
        push_exp(t + 7, F_SRN, 1, "nom_srn_rise");
        push_exp(t + 10, F_RC, 0, "nom_rc_before");
        push_exp(t + 11, F_RC, 1, "nom_rc_first");
        push_exp(t + 12, F_RC, 1, "nom_rc_second");
        push_exp(t + 12, F_ISO, 1, "nom_iso_clear");
        push_exp(t + 13, F_RC, 0, "nom_rc_drop");
        push_exp(t + 13, F_ISO, 0, "nom_iso_drop");
        push_exp(t + 13, F_BUSY, 0, "nom_busy_drop");
        run_to(t + 10);
        rst_stat = 1'b1;
        run_to(t + 11);
        rst_stat = 1'b0;
        run_to(t + 12);
        rst_req = 1'b0;
        run_to(t + 13);

        // back-to-back start, no ack ever: one retry then FAULT
        t = cyc;
        rst_req = 1'b1;
        expect_start(t);
        push_exp(t + 6, F_SRN, 0, "noack_p1_last");
        push_exp(t + 7, F_SRN, 1, "noack_p1_rise");
        push_exp(t + 15, F_SRN, 1, "noack_wait_end");
        push_exp(t + 15, F_RETRY, 0, "noack_retry0");
        push_exp(t + 16, F_SRN, 0, "noack_p2_fall");
        push_exp(t + 16, F_RETRY, 1, "noack_retry1");
        push_exp(t + 19, F_SRN, 0, "noack_p2_last");
        push_exp(t + 20, F_SRN, 1, "noack_p2_rise");
        push_exp(t + 28, F_FAULT, 0, "noack_fault_pre");
        push_exp(t + 29, F_FAULT, 1, "noack_fault_set");
        push_exp(t + 35, F_FAULT, 1, "noack_fault_sticky");
        push_exp(t + 35, F_ISO, 1, "noack_iso_fault");
        push_exp(t + 36, F_FAULT, 0, "noack_fault_clr");
        push_exp(t + 36, F_BUSY, 0, "noack_busy_clr");
        push_exp(t + 36, F_RETRY, 1, "noack_retry_keep");
        irq_q.push_back(t + 29);
        run_to(t + 2);
        rst_req = 1'b0;
        run_to(t + 35);
        clr_fault = 1'b1;
        run_to(t + 36);
        clr_fault = 1'b0;

        // first timeout, ack during second wait
        run_to(cyc + 2);
        t = cyc;
        rst_req = 1'b1;
        expect_start(t);
        push_exp(t + 16, F_RETRY, 1, "retry_cnt1");
        push_exp(t + 16, F_SRN, 0, "retry_p2_fall");
        push_exp(t + 20, F_SRN, 1, "retry_p2_rise");
        push_exp(t + 22, F_RC, 0, "retry_rc_pre");
        push_exp(t + 23, F_RC, 1, "retry_rc_set");
        push_exp(t + 23, F_RETRY, 1, "retry_cnt_clear");
        push_exp(t + 24, F_ISO, 1, "retry_iso_hold");
        push_exp(t + 25, F_ISO, 0, "retry_iso_drop");
        push_exp(t + 25, F_FAULT, 0, "retry_no_fault");
        run_to(t + 22);
        rst_stat = 1'b1;
        run_to(t + 23);
        rst_stat = 1'b0;
        run_to(t + 24);
        rst_req = 1'b0;

        // ack arriving in the timeout cycle wins over retry
        run_to(cyc + 1);
        t = cyc;
        rst_req = 1'b1;
        expect_start(t);
        push_exp(t + 16, F_RC, 1, "race_rc_set");
        push_exp(t + 16, F_SRN, 1, "race_no_pulse");
        push_exp(t + 16, F_RETRY, 0, "race_retry0");
        push_exp(t + 17, F_RC, 0, "race_rc_drop");
        push_exp(t + 17, F_ISO, 0, "race_iso_drop");
        run_to(t + 15);
        rst_stat = 1'b1;
        run_to(t + 16);
        rst_stat = 1'b0;
        rst_req  = 1'b0;

        // guard disabled blocks a start; dropping it mid-sequence does not abort
        run_to(cyc + 1);
        guard_ena = 1'b0;
        t = cyc;
        rst_req = 1'b1;
        push_exp(t + 1, F_BUSY, 0, "dis_busy1");
        push_exp(t + 1, F_ISO, 0, "dis_iso1");
        push_exp(t + 3, F_SRN, 1, "dis_srn3");
        push_exp(t + 5, F_BUSY, 0, "dis_busy5");
        push_exp(t + 5, F_EVT, e_evt, "dis_evt");
        run_to(t + 5);
        rst_req = 1'b0;
        run_to(t + 6);
        guard_ena = 1'b1;
        t2 = cyc;
        rst_req = 1'b1;
        expect_start(t2);
        push_exp(t2 + 6, F_SRN, 0, "drop_srn_low");
        push_exp(t2 + 7, F_SRN, 1, "drop_srn_rise");
        push_exp(t2 + 11, F_RC, 1, "drop_rc_set");
        push_exp(t2 + 12, F_BUSY, 0, "drop_done");
        run_to(t2 + 4);
        guard_ena = 1'b0;
        run_to(t2 + 10);
        rst_stat = 1'b1;
        run_to(t2 + 11);
        rst_stat = 1'b0;
        rst_req  = 1'b0;

        // reset during ASSERT
        run_to(cyc + 1);
        guard_ena = 1'b1;
        t = cyc;
        rst_req = 1'b1;
        expect_start(t);
        push_exp(t + 4, F_SRN, 0, "mid_srn_low");
        push_exp(t + 5, F_SRN, 1, "mid_srn_rel");
        push_exp(t + 5, F_ISO, 0, "mid_iso");
        push_exp(t + 5, F_BUSY, 0, "mid_busy");
        push_exp(t + 5, F_EVT, 0, "mid_evt");
        run_to(t + 4);
        rst_ni = 1'b0;
        run_to(t + 5);
        rst_ni  = 1'b1;
        rst_req = 1'b0;
        e_evt   = 0;

        // event counter saturation over 5 back-to-back sequences
        run_to(cyc + 1);
        rst_stat = 1'b1;
        for (int i = 0; i < 5; i++) begin
            t = cyc;
            rst_req = 1'b1;
            expect_start(t);
            push_exp(t + 8, F_RC, 1, "sat_rc");
            push_exp(t + 9, F_BUSY, 0, "sat_idle");
            run_to(t + 1);
            rst_req = 1'b0;
            run_to(t + 9);
        end
        rst_stat = 1'b0;
        push_exp(cyc + 2, F_EVT, EvtMax, "sat_final");

        run_to(cyc + 6);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: never sampled, required %0d at cycle %0d", e.name, e.val, e.cyc);
        end
        while (irq_q.size() > 0) begin
            int c;
            c = irq_q.pop_front();
            tests++;
            fails++;
            $display("FAIL irq_missing: no pulse, required at cycle %0d", c);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
